// File: rtl/wb_dma_mem_arbiter.sv
// Round-robin Wishbone arbiter merging the CPU window path and the DMA master onto one memory
// slave, one transfer per grant, with a watchdog that terminates grants to an unresponsive slave.
module wb_dma_mem_arbiter #(
   parameter int unsigned              pDATA_WIDTH = 32,
   parameter logic [pDATA_WIDTH-1:0]   MEM_BASE    = 32'h3800_0000,
   parameter logic [pDATA_WIDTH-1:0]   MEM_MASK    = 32'hFF00_0000,
   parameter int unsigned              TIMEOUT     = 255
) (
   input  logic                   wb_clk_i,
   input  logic                   wb_rst_i,
   input  logic                   cpu_stb_i,
   input  logic                   cpu_cyc_i,
   input  logic                   cpu_we_i,
   input  logic [3:0]             cpu_sel_i,
   input  logic [pDATA_WIDTH-1:0] cpu_adr_i,
   input  logic [pDATA_WIDTH-1:0] cpu_dat_i,
   output logic                   cpu_ack_o,
   output logic [pDATA_WIDTH-1:0] cpu_dat_o,
   input  logic                   dma_stb_i,
   input  logic                   dma_cyc_i,
   input  logic                   dma_we_i,
   input  logic [3:0]             dma_sel_i,
   input  logic [pDATA_WIDTH-1:0] dma_adr_i,
   input  logic [pDATA_WIDTH-1:0] dma_dat_i,
   output logic                   dma_ack_o,
   output logic [pDATA_WIDTH-1:0] dma_dat_o,
   output logic                   mem_stb_o,
   output logic                   mem_cyc_o,
   output logic                   mem_we_o,
   output logic [3:0]             mem_sel_o,
   output logic [pDATA_WIDTH-1:0] mem_adr_o,
   output logic [pDATA_WIDTH-1:0] mem_dat_o,
   input  logic                   mem_ack_i,
   input  logic [pDATA_WIDTH-1:0] mem_dat_i,
   output logic                   timeout_o
);

   localparam logic [7:0] CntLast = 8'(TIMEOUT - 1);

   typedef enum logic [1:0] {StIdle, StGntCpu, StGntDma} state_e;

   state_e     state_q, state_d;
   logic       last_grant_q, last_grant_d;  // 0 = CPU, 1 = DMA
   logic [7:0] cnt_q, cnt_d;
   logic       timeout_q, timeout_d;

   logic cpu_req, dma_req, gnt, gnt_dma, req_g, wd_hit, ack_g;
   logic [pDATA_WIDTH-1:0] dat_g;

   assign cpu_req = cpu_stb_i & cpu_cyc_i & ((cpu_adr_i & MEM_MASK) == MEM_BASE);
   assign dma_req = dma_stb_i & dma_cyc_i;
   assign gnt     = (state_q != StIdle);
   assign gnt_dma = (state_q == StGntDma);
   assign req_g   = gnt_dma ? dma_req : cpu_req;
   // A real ack in the last watchdog cycle wins over the timeout.
   assign wd_hit  = gnt & (cnt_q == CntLast) & ~mem_ack_i;
   assign timeout_o = timeout_q;

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      cnt_d        = cnt_q;
      timeout_d    = timeout_q;
      mem_stb_o    = 1'b0;
      mem_cyc_o    = 1'b0;
      mem_we_o     = 1'b0;
      mem_sel_o    = '0;
      mem_adr_o    = '0;
      mem_dat_o    = '0;
      ack_g        = 1'b0;
      dat_g        = '0;

      if (gnt) begin
         mem_stb_o = (gnt_dma ? dma_stb_i : cpu_stb_i) & ~wd_hit;
         mem_cyc_o = (gnt_dma ? dma_cyc_i : cpu_cyc_i) & ~wd_hit;
         mem_we_o  = gnt_dma ? dma_we_i  : cpu_we_i;
         mem_sel_o = gnt_dma ? dma_sel_i : cpu_sel_i;
         mem_adr_o = gnt_dma ? dma_adr_i : cpu_adr_i;
         mem_dat_o = gnt_dma ? dma_dat_i : cpu_dat_i;
         dat_g     = wd_hit ? '0 : mem_dat_i;
         if (!req_g) begin
            state_d = StIdle;  // master aborted: no ack
         end else if (mem_ack_i) begin
            ack_g   = 1'b1;
            state_d = StIdle;
         end else if (wd_hit) begin
            ack_g     = 1'b1;
            timeout_d = 1'b1;
            state_d   = StIdle;
         end else begin
            cnt_d = cnt_q + 8'd1;
         end
      end else begin
         if (cpu_req && (!dma_req || last_grant_q)) begin
            state_d      = StGntCpu;
            last_grant_d = 1'b0;
            cnt_d        = '0;
         end else if (dma_req) begin
            state_d      = StGntDma;
            last_grant_d = 1'b1;
            cnt_d        = '0;
         end
      end
   end

   assign cpu_ack_o = ack_g & ~gnt_dma;
   assign dma_ack_o = ack_g & gnt_dma;
   assign cpu_dat_o = gnt_dma ? '0 : dat_g;
   assign dma_dat_o = gnt_dma ? dat_g : '0;

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state_q      <= StIdle;
         last_grant_q <= 1'b1;
         cnt_q        <= '0;
         timeout_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         cnt_q        <= cnt_d;
         timeout_q    <= timeout_d;
      end
   end

endmodule
